// File: rtl/div_unit_if.sv
// Handshake bundle between the EX stage and the multi-cycle divider.
// EX owns the request side (master). The divider returns the result and stall (slave).
interface div_unit_if #(
  parameter int DW = 32
);
  logic            signed_div_i;
  logic [DW-1:0]   opdata1_i;
  logic [DW-1:0]   opdata2_i;
  logic            start_i;
  logic            annul_i;
  logic [2*DW-1:0] result_o;
  logic            ready_o;
  logic            stallreq_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, stallreq_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, stallreq_o
  );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU.
// It produces one quotient bit per clock and returns {remainder, quotient} for HI/LO.
// Signed operands are divided as magnitudes, and the signs are restored at the end.
module div_unit #(
  parameter int DW = 32
) (
  input  logic     clk,
  input  logic     rst,
  div_unit_if.slave bus
);

  typedef enum logic [1:0] {
    DIV_FREE   = 2'd0,
    DIV_BYZERO = 2'd1,
    DIV_ON     = 2'd2,
    DIV_END    = 2'd3
  } state_t;

  localparam logic [5:0] LAST_CNT = 6'(DW);

  state_t        state;
  logic [5:0]    cnt;
  logic [DW-1:0] rem_q;
  logic [DW-1:0] dvd_q;
  logic [DW-1:0] dvs_q;
  logic          sign1_q;
  logic          sign2_q;
  logic          signed_q;

  logic [DW-1:0] abs1;
  logic [DW-1:0] abs2;
  logic [DW:0]   shifted;
  logic [DW-1:0] diff;
  logic          trial_ok;
  logic [DW-1:0] q_fix;
  logic [DW-1:0] r_fix;

  // Take operand magnitudes for the signed case so the core loop stays unsigned.
  assign abs1 = (bus.signed_div_i && bus.opdata1_i[DW-1]) ? -bus.opdata1_i : bus.opdata1_i;
  assign abs2 = (bus.signed_div_i && bus.opdata2_i[DW-1]) ? -bus.opdata2_i : bus.opdata2_i;

  // Compute one restoring step on {partial_rem, dividend} shifted left by one.
  // The partial remainder is always below the divisor, so the difference fits in DW bits.
  assign shifted  = {rem_q, dvd_q[DW-1]};
  assign trial_ok = (shifted >= {1'b0, dvs_q});
  assign diff     = shifted[DW-1:0] - dvs_q;

  // Apply the sign fixup. The remainder takes the dividend's sign.
  // The most-negative / -1 case wraps naturally.
  assign q_fix = (signed_q && (sign1_q ^ sign2_q)) ? -dvd_q : dvd_q;
  assign r_fix = (signed_q && sign1_q) ? -rem_q : rem_q;

  // Stall EX while a request is pending and no result is available yet.
  assign bus.stallreq_o = bus.start_i & ~bus.annul_i & ~bus.ready_o;

  // Sequencer FSM with registered result and ready outputs; annul has priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= DIV_FREE;
      cnt          <= '0;
      rem_q        <= '0;
      dvd_q        <= '0;
      dvs_q        <= '0;
      sign1_q      <= 1'b0;
      sign2_q      <= 1'b0;
      signed_q     <= 1'b0;
      bus.result_o <= '0;
      bus.ready_o  <= 1'b0;
    end else begin
      case (state)
        DIV_FREE: begin
          bus.result_o <= '0;
          bus.ready_o  <= 1'b0;
          if (bus.start_i && !bus.annul_i) begin
            dvd_q    <= abs1;
            dvs_q    <= abs2;
            rem_q    <= '0;
            sign1_q  <= bus.opdata1_i[DW-1];
            sign2_q  <= bus.opdata2_i[DW-1];
            signed_q <= bus.signed_div_i;
            cnt      <= '0;
            if (bus.opdata2_i == '0) begin
              state <= DIV_BYZERO;
            end else begin
              state <= DIV_ON;
            end
          end
        end

        DIV_BYZERO: begin
          if (bus.annul_i) begin
            state <= DIV_FREE;
          end else begin
            state        <= DIV_END;
            bus.result_o <= '0;
            bus.ready_o  <= 1'b1;
          end
        end

        DIV_ON: begin
          if (bus.annul_i) begin
            state <= DIV_FREE;
            cnt   <= '0;
          end else if (cnt == LAST_CNT) begin
            bus.result_o <= {r_fix, q_fix};
            bus.ready_o  <= 1'b1;
            state        <= DIV_END;
            cnt          <= '0;
          end else begin
            if (trial_ok) begin
              rem_q <= diff;
              dvd_q <= {dvd_q[DW-2:0], 1'b1};
            end else begin
              rem_q <= shifted[DW-1:0];
              dvd_q <= {dvd_q[DW-2:0], 1'b0};
            end
            cnt <= cnt + 6'd1;
          end
        end

        DIV_END: begin
          if (bus.annul_i || !bus.start_i) begin
            state        <= DIV_FREE;
            bus.result_o <= '0;
            bus.ready_o  <= 1'b0;
          end
        end

        default: begin
          state       <= DIV_FREE;
          bus.ready_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit.
// Inputs change on the falling edge, and outputs are sampled on the falling edge.
module tb_div_unit;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  div_unit_if #(.DW(32)) bus ();

  div_unit #(.DW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, 10 time units per period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Start a divide and hold start_i until ready_o rises or the cycle budget runs out.
  // The operands are scrambled after acceptance when requested.
  task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic scramble, output logic [63:0] res, output int cycles);
    @(negedge clk);
    bus.signed_div_i = s;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.annul_i      = 1'b0;
    bus.start_i      = 1'b1;
    cycles = 0;
    while (bus.ready_o !== 1'b1 && cycles < 40) begin
      @(negedge clk);
      cycles++;
      if (scramble) begin
        bus.opdata1_i    = ~a;
        bus.opdata2_i    = b + 32'd3;
        bus.signed_div_i = ~s;
      end
    end
    res = bus.result_o;
  endtask

  // Drop start_i and let the unit return to DIV_FREE
  task automatic release_start();
    @(negedge clk);
    bus.start_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if (bus.ready_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_ready: got %b expected 0", bus.ready_o);
    end
    tests_run++;
    if (bus.result_o !== 64'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_result: got %h expected 0", bus.result_o);
    end
    tests_run++;
    if (bus.stallreq_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_stall: got %b expected 0", bus.stallreq_o);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // DIVU 100/7 with edge-by-edge stall and ready tracking
  task automatic test_divu_basic();
    int bad;
    logic [63:0] held;
    bad = 0;
    @(negedge clk);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd100;
    bus.opdata2_i    = 32'd7;
    bus.start_i      = 1'b1;
    #1;
    tests_run++;
    if (bus.stallreq_o !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL t1_stall_pre: got %b expected 1", bus.stallreq_o);
    end
    for (int k = 0; k <= 32; k++) begin
      @(negedge clk);
      if (bus.ready_o !== 1'b0 || bus.stallreq_o !== 1'b1) bad++;
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("[TB] FAIL t1_stall_window: got %0d bad cycles expected 0", bad);
    end
    @(negedge clk);
    tests_run++;
    if (bus.ready_o !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL t1_ready_edge33: got %b expected 1", bus.ready_o);
    end
    tests_run++;
    if (bus.result_o !== {32'd2, 32'd14}) begin
      tests_failed++;
      $display("[TB] FAIL t1_result: got %h expected %h", bus.result_o, {32'd2, 32'd14});
    end
    tests_run++;
    if (bus.stallreq_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL t1_stall_done: got %b expected 0", bus.stallreq_o);
    end
    held = bus.result_o;
    repeat (2) @(negedge clk);
    tests_run++;
    if (bus.ready_o !== 1'b1 || bus.result_o !== {32'd2, 32'd14}) begin
      tests_failed++;
      $display("[TB] FAIL t1_hold_end: got ready=%b result=%h expected ready=1 result=%h",
               bus.ready_o, bus.result_o, held);
    end
    bus.start_i = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0) begin
      tests_failed++;
      $display("[TB] FAIL t1_drop: got ready=%b result=%h expected ready=0 result=0",
               bus.ready_o, bus.result_o);
    end
  endtask

  // Signed and unsigned sign/magnitude combinations
  task automatic test_signed();
    logic [63:0] res;
    int cyc;
    logic        sv [5];
    logic [31:0] av [5];
    logic [31:0] bv [5];
    logic [63:0] ev [5];
    sv[0] = 1'b1; av[0] = 32'hFFFFFFF9; bv[0] = 32'h2;        ev[0] = 64'hFFFFFFFF_FFFFFFFD;
    sv[1] = 1'b1; av[1] = 32'h7;        bv[1] = 32'hFFFFFFFE; ev[1] = 64'h00000001_FFFFFFFD;
    sv[2] = 1'b1; av[2] = 32'hFFFFFFF9; bv[2] = 32'hFFFFFFFE; ev[2] = 64'hFFFFFFFF_00000003;
    sv[3] = 1'b0; av[3] = 32'hFFFFFFF9; bv[3] = 32'h2;        ev[3] = 64'h00000001_7FFFFFFC;
    sv[4] = 1'b0; av[4] = 32'h1;        bv[4] = 32'hFFFFFFFF; ev[4] = 64'h00000001_00000000;
    for (int i = 0; i < 5; i++) begin
      do_div(sv[i], av[i], bv[i], 1'b0, res, cyc);
      tests_run++;
      if (res !== ev[i] || cyc !== 34) begin
        tests_failed++;
        $display("[TB] FAIL signed_vec%0d: got result=%h cycles=%0d expected result=%h cycles=34",
                 i, res, cyc, ev[i]);
      end
      release_start();
    end
  endtask

  // Overflow wrap and maximum unsigned dividend
  task automatic test_boundaries();
    logic [63:0] res;
    int cyc;
    do_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0, res, cyc);
    tests_run++;
    if (res !== 64'h00000000_80000000 || cyc !== 34) begin
      tests_failed++;
      $display("[TB] FAIL div_min_by_m1: got result=%h cycles=%0d expected result=0000000080000000 cycles=34", res, cyc);
    end
    release_start();
    do_div(1'b0, 32'hFFFFFFFF, 32'h1, 1'b0, res, cyc);
    tests_run++;
    if (res !== 64'h00000000_FFFFFFFF || cyc !== 34) begin
      tests_failed++;
      $display("[TB] FAIL divu_max_by_1: got result=%h cycles=%0d expected result=00000000ffffffff cycles=34", res, cyc);
    end
    release_start();
  endtask

  // Divisor zero short-circuits in both modes
  task automatic test_div_by_zero();
    logic [63:0] res;
    int cyc;
    for (int m = 0; m < 2; m++) begin
      do_div(m[0], 32'd123, 32'd0, 1'b0, res, cyc);
      tests_run++;
      if (res !== 64'h0 || cyc !== 2) begin
        tests_failed++;
        $display("[TB] FAIL byzero_mode%0d: got result=%h cycles=%0d expected result=0 cycles=2", m, res, cyc);
      end
      @(negedge clk);
      bus.start_i = 1'b0;
      @(negedge clk);
      tests_run++;
      if (bus.ready_o !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL byzero_drop%0d: got ready=%b expected 0", m, bus.ready_o);
      end
    end
  endtask

  // Operands that change after acceptance must not affect the result
  task automatic test_operand_hold();
    logic [63:0] res;
    int cyc;
    do_div(1'b0, 32'd100, 32'd7, 1'b1, res, cyc);
    tests_run++;
    if (res !== {32'd2, 32'd14} || cyc !== 34) begin
      tests_failed++;
      $display("[TB] FAIL operand_hold: got result=%h cycles=%0d expected result=%h cycles=34", res, cyc, {32'd2, 32'd14});
    end
    release_start();
  endtask

  // Annul at cnt=10 aborts without a result; annul in DIV_FREE blocks the start
  task automatic test_annul();
    logic [63:0] res;
    int cyc;
    int seen;
    int bad;
    @(negedge clk);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd1000;
    bus.opdata2_i    = 32'd3;
    bus.start_i      = 1'b1;
    repeat (11) @(negedge clk);
    bus.annul_i = 1'b1;
    #1;
    tests_run++;
    if (bus.stallreq_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL annul_stall: got %b expected 0", bus.stallreq_o);
    end
    @(negedge clk);
    tests_run++;
    if (bus.ready_o !== 1'b0 || bus.stallreq_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL annul_next: got ready=%b stall=%b expected 0 0", bus.ready_o, bus.stallreq_o);
    end
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.ready_o !== 1'b0) seen++;
    end
    tests_run++;
    if (seen !== 0) begin
      tests_failed++;
      $display("[TB] FAIL annul_no_ready: got %0d ready cycles expected 0", seen);
    end
    do_div(1'b0, 32'd9, 32'd3, 1'b0, res, cyc);
    tests_run++;
    if (res !== {32'd0, 32'd3} || cyc !== 34) begin
      tests_failed++;
      $display("[TB] FAIL annul_after: got result=%h cycles=%0d expected result=%h cycles=34", res, cyc, {32'd0, 32'd3});
    end
    release_start();

    // Annul held in DIV_FREE keeps the request out
    bad = 0;
    @(negedge clk);
    bus.opdata1_i = 32'd50;
    bus.opdata2_i = 32'd5;
    bus.annul_i   = 1'b1;
    bus.start_i   = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (bus.ready_o !== 1'b0 || bus.stallreq_o !== 1'b0) bad++;
    end
    bus.annul_i = 1'b0;
    cyc = 0;
    while (bus.ready_o !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    tests_run++;
    if (bad !== 0 || cyc !== 34 || bus.result_o !== {32'd0, 32'd10}) begin
      tests_failed++;
      $display("[TB] FAIL annul_free_block: got bad=%0d cycles=%0d result=%h expected bad=0 cycles=34 result=%h",
               bad, cyc, bus.result_o, {32'd0, 32'd10});
    end
    release_start();
  endtask

  // Async reset between edges, both mid-divide and while holding a result
  task automatic test_reset_mid();
    logic [63:0] res;
    int cyc;
    @(negedge clk);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd100;
    bus.opdata2_i    = 32'd7;
    bus.start_i      = 1'b1;
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0) begin
      tests_failed++;
      $display("[TB] FAIL rst_mid_on: got ready=%b result=%h expected 0 0", bus.ready_o, bus.result_o);
    end
    bus.start_i = 1'b0;
    #1 rst = 1'b0;
    do_div(1'b0, 32'd9, 32'd3, 1'b0, res, cyc);
    tests_run++;
    if (res !== {32'd0, 32'd3} || cyc !== 34) begin
      tests_failed++;
      $display("[TB] FAIL rst_then_div: got result=%h cycles=%0d expected result=%h cycles=34", res, cyc, {32'd0, 32'd3});
    end
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0) begin
      tests_failed++;
      $display("[TB] FAIL rst_in_end: got ready=%b result=%h expected 0 0", bus.ready_o, bus.result_o);
    end
    bus.start_i = 1'b0;
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  // Two operations issued one after the other
  task automatic test_back_to_back();
    logic [63:0] res;
    int cyc;
    do_div(1'b0, 32'd77, 32'd5, 1'b0, res, cyc);
    tests_run++;
    if (res !== {32'd2, 32'd15} || cyc !== 34) begin
      tests_failed++;
      $display("[TB] FAIL b2b_first: got result=%h cycles=%0d expected result=%h cycles=34", res, cyc, {32'd2, 32'd15});
    end
    release_start();
    do_div(1'b1, 32'hFFFFFF9C, 32'd9, 1'b0, res, cyc);
    tests_run++;
    if (res !== 64'hFFFFFFFF_FFFFFFF5 || cyc !== 34) begin
      tests_failed++;
      $display("[TB] FAIL b2b_second: got result=%h cycles=%0d expected result=ffffffff_fffffff5 cycles=34", res, cyc);
    end
    release_start();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_divu_basic();
    test_signed();
    test_boundaries();
    test_div_by_zero();
    test_operand_hold();
    test_annul();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
